// File: rtl/ram_dma_pkg.sv
// Shared bus widths, reset level, state/mode encodings and helpers for the RAM DMA engine.
package ram_dma_pkg;

    localparam logic        RstEnable  = 1'b0;
    localparam int unsigned MemAddrBus = 32;
    localparam int unsigned MemBus     = 32;
    localparam logic [MemBus-1:0] ZeroWord = '0;

    localparam int unsigned SEL_W      = MemBus / 8;
    localparam int unsigned WORD_BYTES = MemBus / 8;
    localparam logic [SEL_W-1:0] SEL_ALL  = '1;
    localparam logic [SEL_W-1:0] SEL_NONE = '0;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_READ  = 2'd1,
        DMA_WRITE = 2'd2,
        DMA_DONE  = 2'd3
    } dma_state_e;

    typedef enum logic {
        DMA_MODE_COPY = 1'b0,
        DMA_MODE_FILL = 1'b1
    } dma_mode_e;

    // Source alignment only matters when the source is actually read.
    function automatic logic is_misaligned(input dma_mode_e mode,
                                           input logic [1:0] src_lo,
                                           input logic [1:0] dst_lo);
        return (dst_lo != 2'b00) || ((mode == DMA_MODE_COPY) && (src_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ram_dma_if.sv
// Word-wide RAM port as seen by a bus initiator: req/gnt handshake plus address/data/select.
interface ram_dma_if
    import ram_dma_pkg::*;
#(
    parameter int unsigned AW = MemAddrBus,
    parameter int unsigned DW = MemBus
) ();

    logic          req;
    logic          gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] sel;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata, sel,
        input  gnt, rdata
    );

    modport slave (
        input  req, we, addr, wdata, sel,
        output gnt, rdata
    );

endinterface

// File: rtl/ram_dma.sv
// Block copy / block fill engine acting as a second master on the word-wide RAM port.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned MEM_AW = MemAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              mode_i,
    input  logic [MEM_AW-1:0] src_addr_i,
    input  logic [MEM_AW-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [MemBus-1:0] fill_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    ram_dma_if.master         mem
);

    dma_state_e        state;
    dma_mode_e         mode_q;
    logic [MEM_AW-1:0] src_ptr;
    logic [MEM_AW-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [MemBus-1:0] fill_q;

    dma_mode_e         start_mode_c;
    logic              start_bad_c;
    logic              beat_c;
    logic              last_c;
    logic [MEM_AW-1:0] src_nxt_c;
    logic [MEM_AW-1:0] dst_nxt_c;

    // Decode of the incoming request and the per-beat datapath increments.
    always_comb begin
        start_mode_c = dma_mode_e'(mode_i);
        start_bad_c  = is_misaligned(start_mode_c, src_addr_i[1:0], dst_addr_i[1:0]);
        beat_c       = mem.req && mem.gnt;
        last_c       = (count == LEN_W'(1));
        src_nxt_c    = src_ptr + MEM_AW'(WORD_BYTES);
        dst_nxt_c    = dst_ptr + MEM_AW'(WORD_BYTES);
    end

    // Transfer sequencer; bus outputs are registered and loaded on entry to each state.
    // The write-data register doubles as the copy word buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state     <= DMA_IDLE;
            mode_q    <= DMA_MODE_COPY;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            count     <= '0;
            fill_q    <= ZeroWord;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= ZeroWord;
            mem.sel   <= SEL_NONE;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                DMA_IDLE: begin
                    if (start_i) begin
                        mode_q  <= start_mode_c;
                        src_ptr <= src_addr_i;
                        dst_ptr <= dst_addr_i;
                        count   <= len_i;
                        fill_q  <= fill_data_i;
                        err_o   <= start_bad_c;
                        busy_o  <= 1'b1;
                        if ((len_i == '0) || start_bad_c) begin
                            state  <= DMA_DONE;
                            done_o <= 1'b1;
                        end else if (start_mode_c == DMA_MODE_FILL) begin
                            state     <= DMA_WRITE;
                            mem.req   <= 1'b1;
                            mem.we    <= 1'b1;
                            mem.addr  <= dst_addr_i;
                            mem.wdata <= fill_data_i;
                            mem.sel   <= SEL_ALL;
                        end else begin
                            state     <= DMA_READ;
                            mem.req   <= 1'b1;
                            mem.we    <= 1'b0;
                            mem.addr  <= src_addr_i;
                            mem.wdata <= ZeroWord;
                            mem.sel   <= SEL_ALL;
                        end
                    end
                end

                DMA_READ: begin
                    if (abort_i) begin
                        state     <= DMA_DONE;
                        done_o    <= 1'b1;
                        mem.req   <= 1'b0;
                        mem.we    <= 1'b0;
                        mem.addr  <= '0;
                        mem.wdata <= ZeroWord;
                        mem.sel   <= SEL_NONE;
                    end else if (beat_c) begin
                        state     <= DMA_WRITE;
                        mem.we    <= 1'b1;
                        mem.addr  <= dst_ptr;
                        mem.wdata <= mem.rdata;
                    end
                end

                DMA_WRITE: begin
                    if (beat_c) begin
                        if (mode_q == DMA_MODE_COPY) begin
                            src_ptr <= src_nxt_c;
                        end
                        dst_ptr <= dst_nxt_c;
                        count   <= count - LEN_W'(1);
                    end
                    if (abort_i || (beat_c && last_c)) begin
                        state     <= DMA_DONE;
                        done_o    <= 1'b1;
                        mem.req   <= 1'b0;
                        mem.we    <= 1'b0;
                        mem.addr  <= '0;
                        mem.wdata <= ZeroWord;
                        mem.sel   <= SEL_NONE;
                    end else if (beat_c && (mode_q == DMA_MODE_COPY)) begin
                        state     <= DMA_READ;
                        mem.we    <= 1'b0;
                        mem.addr  <= src_nxt_c;
                        mem.wdata <= ZeroWord;
                    end else if (beat_c) begin
                        mem.addr  <= dst_nxt_c;
                        mem.wdata <= fill_q;
                    end
                end

                DMA_DONE: begin
                    state  <= DMA_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state  <= DMA_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Randomized and directed checks of ram_dma against an array-based transfer model.
module tb_ram_dma;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] fill;
    logic        busy;
    logic        done;
    logic        err;
    logic        fill_mem;

    logic [31:0] ram [0:255];
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];

    int vectors;
    int miscompares;

    ram_dma_if #(.AW(32), .DW(32)) mif ();

    ram_dma #(.LEN_W(16), .MEM_AW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .abort_i     (abort),
        .mode_i      (mode),
        .src_addr_i  (src),
        .dst_addr_i  (dst),
        .len_i       (len),
        .fill_data_i (fill),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .mem         (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 KB RAM model: combinational read, write on granted write beats.
    always_comb mif.rdata = ram[mif.addr[9:2]];

    always @(posedge clk) begin
        if (fill_mem) begin
            for (int i = 0; i < 256; i++) ram[i] <= $urandom();
        end else if (mif.req && mif.gnt && mif.we) begin
            ram[mif.addr[9:2]] <= mif.wdata;
            wlog_a.push_back(mif.addr);
            wlog_d.push_back(mif.wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // pol: 0 continuous grant, 1 toggling 1-0-1-0, 2 random grant.
    task automatic run_xfer(input string tag, input logic m, input logic [31:0] s,
                            input logic [31:0] d, input logic [15:0] l, input logic [31:0] f,
                            input int pol, input int abort_beat, input bit stray_start);
        logic [31:0] model [0:255];
        logic [31:0] exp_a [$];
        logic [31:0] exp_d [$];
        logic [31:0] p_addr, p_data;
        logic        p_we;
        bit exp_err, done_seen, pend, tgl, saw_req;
        int words, exp_done_cyc, cyc, rd_beats, diffs, n;

        // Reference: ascending word-by-word copy/fill on a snapshot of memory.
        model   = ram;
        exp_err = (d[1:0] != 2'b00) || ((m == 1'b0) && (s[1:0] != 2'b00));
        words   = exp_err ? 0 : int'(l);
        if ((abort_beat > 0) && (words > abort_beat - 1)) words = abort_beat - 1;
        for (int i = 0; i < words; i++) begin
            logic [31:0] wa, ra, wd;
            wa = d + 32'(4 * i);
            ra = s + 32'(4 * i);
            wd = m ? f : model[ra[9:2]];
            model[wa[9:2]] = wd;
            exp_a.push_back(wa);
            exp_d.push_back(wd);
        end
        exp_done_cyc = (words == 0) ? 1 : (m ? words + 1 : 2 * words + 1);

        wlog_a.delete();
        wlog_d.delete();
        mif.gnt = 1'b0;
        mode = m; src = s; dst = d; len = l; fill = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        cyc = 0; done_seen = 0; pend = 0; tgl = 1; rd_beats = 0; saw_req = 0;
        p_addr = '0; p_data = '0; p_we = 1'b0;
        while (!done_seen && (cyc < 400)) begin
            cyc++;
            if (cyc == 1) begin
                check({tag, "_busy"}, 64'(busy), 64'(1));
                check({tag, "_err_on_start"}, 64'(err), 64'(exp_err));
            end
            if (pend) check({tag, "_stall_hold"}, {31'd0, mif.we, mif.addr}, {31'd0, p_we, p_addr});
            if (pend) check({tag, "_stall_data"}, 64'(mif.wdata), 64'(p_data));
            if (mif.req) saw_req = 1;
            if (done) begin
                done_seen = 1;
            end else begin
                case (pol)
                    0:       mif.gnt = 1'b1;
                    1:       begin mif.gnt = tgl; tgl = !tgl; end
                    default: mif.gnt = ($urandom_range(0, 3) != 0);
                endcase
                if (mif.req && !mif.we && mif.gnt) begin
                    rd_beats++;
                    if (rd_beats == abort_beat) abort = 1'b1;
                end
                pend   = mif.req && !mif.gnt && !abort;
                p_addr = mif.addr;
                p_data = mif.wdata;
                p_we   = mif.we;
                if (stray_start && (cyc == 2)) begin
                    start = 1'b1; mode = 1'b1; dst = 32'h3; len = 16'd5; fill = 32'h1234_5678;
                end
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
            end
        end

        check({tag, "_done_seen"}, 64'(done_seen), 64'(1));
        if ((pol == 0) && (abort_beat == 0)) check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done_cyc));
        check({tag, "_done_ctrl_zero"}, {57'd0, mif.req, mif.we, mif.sel, busy}, {63'd0, 1'b1});
        check({tag, "_done_bus_zero"}, {mif.addr, mif.wdata}, 64'd0);
        check({tag, "_err_at_done"}, 64'(err), 64'(exp_err));
        if (words == 0) check({tag, "_no_bus"}, 64'(saw_req), 64'(0));

        mif.gnt = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {61'd0, busy, done, err}, {61'd0, 1'b0, 1'b0, exp_err});

        check({tag, "_write_count"}, 64'(wlog_a.size()), 64'(exp_a.size()));
        n = (wlog_a.size() < exp_a.size()) ? wlog_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), 64'(wlog_a[i]), 64'(exp_a[i]));
            check($sformatf("%s_wdata%0d", tag, i), 64'(wlog_d[i]), 64'(exp_d[i]));
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== model[i]) diffs++;
        check({tag, "_mem_image"}, 64'(diffs), 64'(0));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        src = '0; dst = '0; len = '0; fill = '0; mif.gnt = 1'b0; fill_mem = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fill_mem = 1'b0;
        check("reset_ctrl", {55'd0, busy, done, err, mif.req, mif.we, mif.sel}, 64'd0);
        check("reset_bus", {mif.addr, mif.wdata}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_xfer("copy3", 1'b0, 32'h100, 32'h200, 16'd3, 32'h0, 0, 0, 0);
        run_xfer("fill_stall", 1'b1, 32'h0, 32'h040, 16'd4, 32'hDEADBEEF, 1, 0, 0);
        run_xfer("len0", 1'b0, 32'h100, 32'h200, 16'd0, 32'h0, 0, 0, 0);
        run_xfer("dst_misalign", 1'b0, 32'h100, 32'h202, 16'd3, 32'h0, 0, 0, 0);
        run_xfer("err_clear", 1'b0, 32'h300, 32'h380, 16'd2, 32'h0, 0, 0, 0);
        run_xfer("src_misalign", 1'b0, 32'h101, 32'h200, 16'd2, 32'h0, 0, 0, 0);
        run_xfer("fill_src_ignored", 1'b1, 32'h101, 32'h2C0, 16'd2, 32'hA5A5_0F0F, 0, 0, 0);
        run_xfer("abort", 1'b0, 32'h000, 32'h200, 16'd8, 32'h0, 0, 3, 0);
        run_xfer("wrap_fill", 1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'hCAFE_F00D, 0, 0, 0);
        run_xfer("stray_start", 1'b0, 32'h020, 32'h140, 16'd4, 32'h0, 0, 0, 1);
        run_xfer("overlap_copy", 1'b0, 32'h180, 32'h184, 16'd4, 32'h0, 0, 0, 0);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] rs, rd;
            rs = 32'($urandom_range(0, 255)) << 2;
            rd = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) rd[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
            run_xfer($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), rs, rd,
                     16'($urandom_range(0, 12)), $urandom(), 2, 0, 0);
        end

        // Asynchronous reset in the middle of a write cycle.
        mode = 1'b1; src = '0; dst = 32'h80; len = 16'd4; fill = 32'h5555_AAAA;
        mif.gnt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_write", {62'd0, mif.req, mif.we}, {62'd0, 1'b1, 1'b1});
        #3 rst = 1'b0;
        #1;
        check("rst_async_ctrl", {55'd0, busy, done, err, mif.req, mif.we, mif.sel}, 64'd0);
        check("rst_async_bus", {mif.addr, mif.wdata}, 64'd0);
        mif.gnt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_release_idle", {62'd0, busy, mif.req}, 64'd0);

        run_xfer("after_reset", 1'b0, 32'h040, 32'h240, 16'd3, 32'h0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
